// File: rtl/encrypt_v4_if.sv
// Handshake bundle for the pipelined encryption engine: input block stream in,
// ciphertext stream out, plus a busy indication.
interface encrypt_v4_if #(
    parameter int N_B = 64,
    parameter int N_K = 128,
    parameter int W_T = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [N_K-1:0] k;
    logic [N_B-1:0] m;
    logic [W_T-1:0] in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [N_B-1:0] c;
    logic [W_T-1:0] out_tag;
    logic           busy;

    modport master (
        output in_valid, k, m, in_tag, out_ready,
        input  in_ready, out_valid, c, out_tag, busy
    );

    modport slave (
        input  in_valid, k, m, in_tag, out_ready,
        output in_ready, out_valid, c, out_tag, busy
    );
endinterface

// File: rtl/encrypt_v4.sv
// Fully pipelined N_R-round block cipher with U rounds per stage, valid/ready
// back-pressure with bubble collapsing, and a caller tag travelling with each block.
module encrypt_v4 #(
    parameter int N_B = 64,
    parameter int N_K = 128,
    parameter int N_R = 8,
    parameter int U   = 1,
    parameter int W_T = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    encrypt_v4_if.slave  bus
);
    localparam int S = N_R / U;

    logic [S-1:0]   v_vec;
    logic [N_B-1:0] x_q  [S];
    logic [N_K-1:0] rk_q [S];
    logic [W_T-1:0] t_q  [S];

    // Round: key mix, rotate, nonlinear AND-feedback, then add upper key word and round index.
    function automatic logic [N_B-1:0] round_fn(
        input logic [N_B-1:0] x,
        input logic [N_K-1:0] rk,
        input logic [31:0]    rnd
    );
        logic [N_B-1:0] y;
        y = x ^ rk[N_B-1:0];
        y = {y[N_B-4:0], y[N_B-1:N_B-3]};
        y = y ^ ({y[N_B-2:0], 1'b0} & {y[N_B-3:0], 2'b00});
        y = y + rk[N_K-1 -: N_B] + N_B'(rnd);
        return y;
    endfunction

    // Key schedule step: rotate left by 13 and fold in a round-dependent constant.
    function automatic logic [N_K-1:0] key_step(
        input logic [N_K-1:0] rk,
        input logic [31:0]    rnd
    );
        logic [N_K-1:0] r;
        r = {rk[N_K-14:0], rk[N_K-1:N_K-13]};
        r = r ^ N_K'(32'h9E37_79B9 + rnd);
        return r;
    endfunction

    for (genvar j = 0; j < S; j++) begin : g_stage
        logic           v_r;
        logic [N_B-1:0] x_r;
        logic [N_K-1:0] rk_r;
        logic [W_T-1:0] t_r;
        logic           v_up;
        logic [N_B-1:0] x_up;
        logic [N_K-1:0] rk_up;
        logic [W_T-1:0] t_up;
        logic [N_B-1:0] x_nx;
        logic [N_K-1:0] rk_nx;
        logic           ld;

        if (j == 0) begin : g_src
            assign v_up  = bus.in_valid;
            assign x_up  = bus.m;
            assign rk_up = bus.k;
            assign t_up  = bus.in_tag;
        end else begin : g_src
            assign v_up  = v_vec[j-1];
            assign x_up  = x_q[j-1];
            assign rk_up = rk_q[j-1];
            assign t_up  = t_q[j-1];
        end

        // A stage can load unless it and every stage downstream are full and the sink stalls.
        assign ld = ~(&v_vec[S-1:j]) | bus.out_ready;

        assign v_vec[j] = v_r;
        assign x_q[j]   = x_r;
        assign rk_q[j]  = rk_r;
        assign t_q[j]   = t_r;

        // Apply this stage's U rounds; the last stage also applies the output whitening.
        always_comb begin
            x_nx  = x_up;
            rk_nx = rk_up;
            for (int i = 0; i < U; i++) begin
                x_nx  = round_fn(x_nx, rk_nx, 32'(j * U + i));
                rk_nx = key_step(rk_nx, 32'(j * U + i));
            end
            x_nx = (j == S - 1) ? (x_nx ^ rk_nx[N_B-1:0]) : x_nx;
        end

        // Stage register: valid follows upstream on load; data only captured for real blocks.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r  <= 1'b0;
                x_r  <= '0;
                rk_r <= '0;
                t_r  <= '0;
            end else if (ld) begin
                v_r <= v_up;
                if (v_up) begin
                    x_r  <= x_nx;
                    rk_r <= rk_nx;
                    t_r  <= t_up;
                end
            end
        end
    end

    assign bus.in_ready  = rst_n & (~(&v_vec) | bus.out_ready);
    assign bus.out_valid = v_vec[S-1];
    assign bus.c         = x_q[S-1];
    assign bus.out_tag   = t_q[S-1];
    assign bus.busy      = |v_vec;
endmodule
